// File: rtl/pipe_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl_pkg : stall bus type, stall vectors and MC FSM encodings
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_stall_ctrl_pkg;

    localparam logic c_stop    = 1'b1;
    localparam logic c_no_stop = 1'b0;

    // Bit map: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
    typedef logic [5:0] stall_bus_t;

    localparam stall_bus_t c_stall_none = 6'b000000;
    localparam stall_bus_t c_stall_if   = 6'b000011;
    localparam stall_bus_t c_stall_id   = 6'b000111;
    localparam stall_bus_t c_stall_ex   = 6'b001111;
    localparam stall_bus_t c_stall_mem  = 6'b011111;

    localparam int c_id_stall_bit = 2;

    localparam logic [1:0] c_mc_idle = 2'd0;
    localparam logic [1:0] c_mc_busy = 2'd1;
    localparam logic [1:0] c_mc_done = 2'd2;

endpackage

`default_nettype wire

// File: rtl/pipe_stall_ctrl_mc_seq.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl_mc_seq : IDLE/BUSY/DONE countdown sequencer for mul/div in EX
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stall_ctrl_mc_seq
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    input  logic                hold_done,
    output logic                mc_stall,
    output logic                mc_done
);

    localparam logic [MC_CNT_W-1:0] c_one = {{(MC_CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [MC_CNT_W-1:0] r_cnt;
    logic [MC_CNT_W-1:0] w_next_cnt;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        mc_stall     = 1'b0;
        mc_done      = 1'b0;
        case (r_state)
            c_mc_idle: begin
                // A zero-length request is not a multi-cycle op at all
                if (mc_start && (mc_cycles != '0)) begin
                    mc_stall = 1'b1;
                    if (mc_cycles == c_one) begin
                        w_next_state = c_mc_done;
                    end else begin
                        w_next_state = c_mc_busy;
                        w_next_cnt   = mc_cycles - c_one;
                    end
                end
            end
            c_mc_busy: begin
                mc_stall = 1'b1;
                if (r_cnt == c_one) begin
                    w_next_state = c_mc_done;
                end else begin
                    w_next_cnt = r_cnt - c_one;
                end
            end
            c_mc_done: begin
                // Result must stay valid while MEM keeps EX frozen
                mc_done = 1'b1;
                if (!hold_done) begin
                    w_next_state = c_mc_idle;
                end
            end
            default: begin
                w_next_state = c_mc_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_mc_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl : pipeline stall/flush controller with stall-cycle counter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MC_CNT_W    = 6,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_if,
    input  logic                   stallreq_mem,
    input  logic                   id_reg1_read,
    input  logic [4:0]             id_reg1_addr,
    input  logic                   id_reg2_read,
    input  logic [4:0]             id_reg2_addr,
    input  logic                   ex_wreg,
    input  logic [4:0]             ex_wd,
    input  logic                   ex_is_load,
    input  logic                   ex_mc_start,
    input  logic [MC_CNT_W-1:0]    ex_mc_cycles,
    input  logic                   id_branch_flag,
    output logic [5:0]             stall,
    output logic                   flush_if_id,
    output logic                   mc_done,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic       w_mc_stall;
    logic       w_mc_done;
    logic       w_load_use;
    stall_bus_t w_stall;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    pipe_stall_ctrl_mc_seq #(
        .MC_CNT_W (MC_CNT_W)
    ) u_mc_seq (
        .clk       (clk),
        .rst       (rst),
        .mc_start  (ex_mc_start),
        .mc_cycles (ex_mc_cycles),
        .hold_done (stallreq_mem),
        .mc_stall  (w_mc_stall),
        .mc_done   (w_mc_done)
    );

    assign w_load_use = ex_is_load && ex_wreg && (ex_wd != 5'd0) &&
                        ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                         (id_reg2_read && (id_reg2_addr == ex_wd)));

    always_comb begin
        w_stall = c_stall_none;
        if (stallreq_mem) begin
            w_stall = c_stall_mem;
        end else if (w_mc_stall) begin
            w_stall = c_stall_ex;
        end else if (w_load_use) begin
            w_stall = c_stall_id;
        end else if (stallreq_if) begin
            w_stall = c_stall_if;
        end
    end

    // Outputs are forced quiet for the whole reset pulse, not just at edges
    assign stall       = rst ? c_stall_none : w_stall;
    assign mc_done     = !rst && w_mc_done;
    assign flush_if_id = !rst && id_branch_flag && (stall[c_id_stall_bit] == c_no_stop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall[0] == c_stop && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_stall_ctrl : directed self-checking bench for pipe_stall_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stall_ctrl;

    logic       clk;
    logic       rst;
    logic       stallreq_if;
    logic       stallreq_mem;
    logic       id_reg1_read;
    logic [4:0] id_reg1_addr;
    logic       id_reg2_read;
    logic [4:0] id_reg2_addr;
    logic       ex_wreg;
    logic [4:0] ex_wd;
    logic       ex_is_load;
    logic       ex_mc_start;
    logic [5:0] ex_mc_cycles;
    logic       id_branch_flag;
    logic [5:0] stall;
    logic       flush_if_id;
    logic       mc_done;
    logic [3:0] stall_cnt;

    int         total;
    int         bad;
    logic [3:0] ec;

    // Narrow counter so saturation is reachable in a short run
    pipe_stall_ctrl #(
        .MC_CNT_W    (6),
        .STALL_CNT_W (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stallreq_if    (stallreq_if),
        .stallreq_mem   (stallreq_mem),
        .id_reg1_read   (id_reg1_read),
        .id_reg1_addr   (id_reg1_addr),
        .id_reg2_read   (id_reg2_read),
        .id_reg2_addr   (id_reg2_addr),
        .ex_wreg        (ex_wreg),
        .ex_wd          (ex_wd),
        .ex_is_load     (ex_is_load),
        .ex_mc_start    (ex_mc_start),
        .ex_mc_cycles   (ex_mc_cycles),
        .id_branch_flag (id_branch_flag),
        .stall          (stall),
        .flush_if_id    (flush_if_id),
        .mc_done        (mc_done),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        stallreq_if    = 1'b0;
        stallreq_mem   = 1'b0;
        id_reg1_read   = 1'b0;
        id_reg1_addr   = 5'd0;
        id_reg2_read   = 1'b0;
        id_reg2_addr   = 5'd0;
        ex_wreg        = 1'b0;
        ex_wd          = 5'd0;
        ex_is_load     = 1'b0;
        ex_mc_start    = 1'b0;
        ex_mc_cycles   = 6'd0;
        id_branch_flag = 1'b0;
    endtask

    // Check combinational outputs for this cycle, clock it, then check counter
    task automatic step(input string tag, input logic [5:0] es, input logic ef, input logic ed);
        #1;
        chk({tag, ".stall"}, {26'd0, stall}, {26'd0, es});
        chk({tag, ".flush"}, {31'd0, flush_if_id}, {31'd0, ef});
        chk({tag, ".done"}, {31'd0, mc_done}, {31'd0, ed});
        @(posedge clk);
        if (es[0] && ec != 4'hF) ec = ec + 4'd1;
        #1;
        chk({tag, ".cnt"}, {28'd0, stall_cnt}, {28'd0, ec});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        ec    = 4'd0;
        clk   = 1'b0;
        rst   = 1'b1;
        clear_inputs();
        // Everything asserted during reset must be masked
        stallreq_mem   = 1'b1;
        ex_mc_start    = 1'b1;
        ex_mc_cycles   = 6'd3;
        id_branch_flag = 1'b1;
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd5;
        id_reg2_read = 1'b1; id_reg2_addr = 5'd5;
        #1;
        chk("rst.stall", {26'd0, stall}, 32'd0);
        chk("rst.flush", {31'd0, flush_if_id}, 32'd0);
        chk("rst.done", {31'd0, mc_done}, 32'd0);
        chk("rst.cnt", {28'd0, stall_cnt}, 32'd0);
        @(posedge clk); #1;
        chk("rst2.stall", {26'd0, stall}, 32'd0);
        chk("rst2.cnt", {28'd0, stall_cnt}, 32'd0);
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;

        // Load-use via rs2, then rd=x0, then branch gating
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd5;
        id_reg2_read = 1'b1; id_reg2_addr = 5'd5;
        step("lu_rs2", 6'b000111, 1'b0, 1'b0);
        ex_wd = 5'd0; id_reg2_addr = 5'd0;
        step("lu_x0", 6'b000000, 1'b0, 1'b0);
        id_branch_flag = 1'b1;
        step("br_free", 6'b000000, 1'b1, 1'b0);
        ex_wd = 5'd5; id_reg2_addr = 5'd5;
        step("br_lu", 6'b000111, 1'b0, 1'b0);
        id_branch_flag = 1'b0;
        id_reg2_read = 1'b0; id_reg1_read = 1'b1; id_reg1_addr = 5'd5;
        step("lu_rs1", 6'b000111, 1'b0, 1'b0);
        id_reg1_addr = 5'd6;
        step("lu_miss", 6'b000000, 1'b0, 1'b0);
        id_reg1_addr = 5'd5; ex_is_load = 1'b0;
        step("lu_noload", 6'b000000, 1'b0, 1'b0);
        clear_inputs();

        // Multi-cycle N=3, start held through DONE
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd3;
        step("mc3_c0", 6'b001111, 1'b0, 1'b0);
        step("mc3_c1", 6'b001111, 1'b0, 1'b0);
        step("mc3_c2", 6'b001111, 1'b0, 1'b0);
        step("mc3_c3", 6'b000000, 1'b0, 1'b1);
        ex_mc_start = 1'b0;
        step("mc3_c4", 6'b000000, 1'b0, 1'b0);

        // Multi-cycle N=2 overlapped by a MEM stall in c1..c3
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd2;
        step("mc2_c0", 6'b001111, 1'b0, 1'b0);
        stallreq_mem = 1'b1;
        step("mc2_c1", 6'b011111, 1'b0, 1'b0);
        step("mc2_c2", 6'b011111, 1'b0, 1'b1);
        step("mc2_c3", 6'b011111, 1'b0, 1'b1);
        stallreq_mem = 1'b0;
        step("mc2_c4", 6'b000000, 1'b0, 1'b1);
        ex_mc_start = 1'b0;
        step("mc2_c5", 6'b000000, 1'b0, 1'b0);

        // N=1 outranking a load-use, then N=0 ignored
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd1;
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd7;
        id_reg1_read = 1'b1; id_reg1_addr = 5'd7;
        step("mc1_c0", 6'b001111, 1'b0, 1'b0);
        clear_inputs();
        step("mc1_c1", 6'b000000, 1'b0, 1'b1);
        step("mc1_c2", 6'b000000, 1'b0, 1'b0);
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd0;
        step("mc0_c0", 6'b000000, 1'b0, 1'b0);
        step("mc0_c1", 6'b000000, 1'b0, 1'b0);
        clear_inputs();

        // Request priority
        stallreq_if = 1'b1; stallreq_mem = 1'b1;
        step("pri_both", 6'b011111, 1'b0, 1'b0);
        stallreq_mem = 1'b0;
        step("pri_if", 6'b000011, 1'b0, 1'b0);
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd9;
        id_reg2_read = 1'b1; id_reg2_addr = 5'd9;
        step("pri_if_lu", 6'b000111, 1'b0, 1'b0);
        clear_inputs();

        // IF stall leaves ID free, so a branch still flushes; counter saturates
        stallreq_if = 1'b1; id_branch_flag = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step("sat", 6'b000011, 1'b1, 1'b0);
        end
        clear_inputs();
        step("sat_hold", 6'b000000, 1'b0, 1'b0);

        // Reset pulse between edges in the middle of a 10-cycle op
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd10;
        step("rb_c0", 6'b001111, 1'b0, 1'b0);
        step("rb_c1", 6'b001111, 1'b0, 1'b0);
        step("rb_c2", 6'b001111, 1'b0, 1'b0);
        step("rb_c3", 6'b001111, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        id_branch_flag = 1'b1;
        ec = 4'd0;
        #1;
        chk("rb_rst.stall", {26'd0, stall}, 32'd0);
        chk("rb_rst.done", {31'd0, mc_done}, 32'd0);
        chk("rb_rst.flush", {31'd0, flush_if_id}, 32'd0);
        chk("rb_rst.cnt", {28'd0, stall_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 12; i++) begin
            step("rb_after", 6'b000000, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
